// File: rtl/chess_clock_scheduler.sv
// Two-player chess game clock: synchronises start/stop and move-turn, divides the system clock
// into 1 s ticks and counts the side to move down in BCD m:ss, flagging whoever runs out.
module chess_clock_scheduler #(
    parameter int TICK_DIV       = 50_000_000,
    parameter int START_MINS     = 5,
    parameter int INCREMENT_SECS = 0
) (
    input  logic       clock,
    input  logic       globalReset_n,
    input  logic       startStop,
    input  logic       player,
    input  logic       newGame,
    output logic [3:0] whiteMins,
    output logic [2:0] whiteSecTens,
    output logic [3:0] whiteSecUnits,
    output logic [3:0] blackMins,
    output logic [2:0] blackSecTens,
    output logic [3:0] blackSecUnits,
    output logic       whiteRun,
    output logic       blackRun,
    output logic       whiteFlag,
    output logic       blackFlag,
    output logic [1:0] clockState
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [10:0]   START_TIME = {4'(START_MINS), 3'd0, 4'd0};
    localparam logic [10:0]   MAX_TIME   = {4'd9, 3'd5, 4'd9};
    localparam logic [4:0]    INC        = 5'(INCREMENT_SECS);

    // Times are packed {mins[3:0], tens[2:0], units[3:0]}.
    function automatic logic [10:0] time_dec(input logic [10:0] t);
        logic [3:0] m;
        logic [2:0] s10;
        logic [3:0] s1;
        m   = t[10:7];
        s10 = t[6:4];
        s1  = t[3:0];
        if (t != 11'd0) begin
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd9;
                if (s10 != 3'd0) begin
                    s10 = s10 - 3'd1;
                end else begin
                    s10 = 3'd5;
                    m   = m - 4'd1;
                end
            end
        end
        return {m, s10, s1};
    endfunction

    function automatic logic [10:0] time_inc_sat(input logic [10:0] t);
        logic [4:0]  u;
        logic [3:0]  s10;
        logic [4:0]  m;
        logic [10:0] r;
        u   = {1'b0, t[3:0]} + INC;
        s10 = {1'b0, t[6:4]};
        m   = {1'b0, t[10:7]};
        if (u >= 5'd10) begin
            u   = u - 5'd10;
            s10 = s10 + 4'd1;
        end
        if (s10 >= 4'd6) begin
            s10 = 4'd0;
            m   = m + 5'd1;
        end
        if (m > 5'd9) r = MAX_TIME;
        else          r = {m[3:0], s10[2:0], u[3:0]};
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    ss_sync_q, ss_sync_d;
    logic [2:0]    pl_sync_q, pl_sync_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [10:0]   white_q, white_d;
    logic [10:0]   black_q, black_d;
    logic          white_flag_q, white_flag_d;
    logic          black_flag_q, black_flag_d;

    logic        ss_rise, ss_fall, pl_edge, pl_now, running, tick, time_out;
    logic [10:0] active_time, dec_time;

    // Bit 1 of each chain is the synchronised level, bit 2 its previous value for edge detection.
    assign ss_rise     = ss_sync_q[1] & ~ss_sync_q[2];
    assign ss_fall     = ~ss_sync_q[1] & ss_sync_q[2];
    assign pl_edge     = pl_sync_q[1] ^ pl_sync_q[2];
    assign pl_now      = pl_sync_q[2];
    assign running     = (state_q == S_RUN);
    assign active_time = pl_now ? black_q : white_q;
    assign dec_time    = time_dec(active_time);
    assign tick        = running && (presc_q == PRESC_MAX) && !pl_edge;
    assign time_out    = tick && (active_time != 11'd0) && (dec_time == 11'd0);

    always_ff @(posedge clock or negedge globalReset_n) begin
        if (!globalReset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (newGame) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (ss_rise) state_d = S_RUN;
                S_RUN: begin
                    if (time_out)     state_d = S_TIMEOUT;
                    else if (ss_fall) state_d = S_PAUSED;
                end
                S_PAUSED: if (ss_rise) state_d = S_RUN;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge globalReset_n) begin
        if (!globalReset_n) begin
            ss_sync_q    <= '0;
            pl_sync_q    <= '0;
            presc_q      <= '0;
            white_q      <= START_TIME;
            black_q      <= START_TIME;
            white_flag_q <= 1'b0;
            black_flag_q <= 1'b0;
        end else begin
            ss_sync_q    <= ss_sync_d;
            pl_sync_q    <= pl_sync_d;
            presc_q      <= presc_d;
            white_q      <= white_d;
            black_q      <= black_d;
            white_flag_q <= white_flag_d;
            black_flag_q <= black_flag_d;
        end
    end

    always_comb begin
        ss_sync_d    = {ss_sync_q[1:0], startStop};
        pl_sync_d    = {pl_sync_q[1:0], player};
        presc_d      = presc_q;
        white_d      = white_q;
        black_d      = black_q;
        white_flag_d = white_flag_q;
        black_flag_d = black_flag_q;
        if (newGame) begin
            presc_d      = '0;
            white_d      = START_TIME;
            black_d      = START_TIME;
            white_flag_d = 1'b0;
            black_flag_d = 1'b0;
        end else if (state_q == S_IDLE && ss_rise) begin
            presc_d = '0;
        end else if (running) begin
            // A hand-over restarts the second and credits the side that just moved.
            if (pl_edge) begin
                presc_d = '0;
                if (pl_now) black_d = time_inc_sat(black_q);
                else        white_d = time_inc_sat(white_q);
            end else if (presc_q == PRESC_MAX) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
            if (tick && active_time != 11'd0) begin
                if (pl_now) black_d = dec_time;
                else        white_d = dec_time;
                if (time_out) begin
                    if (pl_now) black_flag_d = 1'b1;
                    else        white_flag_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        {whiteMins, whiteSecTens, whiteSecUnits} = white_q;
        {blackMins, blackSecTens, blackSecUnits} = black_q;
        whiteRun   = (state_q == S_RUN) && !pl_now;
        blackRun   = (state_q == S_RUN) && pl_now;
        whiteFlag  = white_flag_q;
        blackFlag  = black_flag_q;
        clockState = state_q;
    end

endmodule
